bus_rr_arbiter: RTL and testbench
=================================

# bus_rr_arbiter

Round-robin host arbiter and address router for the simulation system bus. It shares single-cycle-latency devices (RAM, test utility) between several hosts: core instruction port, core data port and test-utility host. Each cycle it grants at most one host and routes that request to the matching device. It tracks the in-flight response and steers it back to the granted host. Unmapped addresses complete with a bus error, so a host is never left waiting.

## Interface
- NrHosts, 3, number of requesting hosts (2..8)
- NrDevices, 2, number of target devices (1..8)
- DataWidth, 32, data bus width
- AddressWidth, 32, address bus width

- clk_i  input  1  system clock
- rst_i  input  1  asynchronous, active-high reset
- host_req_i  input  [NrHosts] x 1  host request
- host_gnt_o  output  [NrHosts] x 1  grant, one-hot or zero
- host_addr_i  input  [NrHosts] x AddressWidth  byte address
- host_we_i  input  [NrHosts] x 1  write enable
- host_be_i  input  [NrHosts] x DataWidth/8  byte enables
- host_wdata_i  input  [NrHosts] x DataWidth  write data
- host_rvalid_o  output  [NrHosts] x 1  response valid, one-hot or zero
- host_rdata_o  output  [NrHosts] x DataWidth  response data, same value broadcast to all hosts
- host_err_o  output  [NrHosts] x 1  response error, qualified by host_rvalid_o
- device_req_o  output  [NrDevices] x 1  device request, one-hot or zero
- device_addr_o / device_we_o / device_be_o / device_wdata_o  output  [NrDevices] x widths as host  forwarded request fields, driven from the granted host to all devices
- device_rvalid_i  input  [NrDevices] x 1  device response valid
- device_rdata_i  input  [NrDevices] x DataWidth  device read data
- device_err_i  input  [NrDevices] x 1  device error
- cfg_device_addr_base  input  [NrDevices] x AddressWidth  region base
- cfg_device_addr_mask  input  [NrDevices] x AddressWidth  region mask; a device matches when (addr & mask) == base

## Operation
- Registered state:
  - prio_q: next-priority host index, reset 0
  - rsp_pend_q: reset 0
  - rsp_host_q, rsp_dev_q, rsp_decerr_q: reset 0
- Arbitration (combinational):
  - Scan hosts prio_q, prio_q+1, … modulo NrHosts.
  - The first host with host_req_i=1 wins.
  - host_gnt_o[win]=1. All other grants are 0.
- Pointer update: on a grant, prio_q <= (win+1) mod NrHosts. With no grant, prio_q holds.
- Decode:
  - The lowest-index device matching the winner's address is selected.
  - device_req_o[sel]=1, and the request fields are forwarded.
  - With no match, no device_req_o is raised. The host is still granted and rsp_decerr_q is set.
- Response capture: on a grant, rsp_pend_q <= 1 and rsp_host_q <= win. rsp_dev_q <= sel, and rsp_decerr_q <= (no match). With no grant, rsp_pend_q <= 0.
- Response return:
  - When rsp_pend_q=1, host_rvalid_o[rsp_host_q] = rsp_decerr_q | device_rvalid_i[rsp_dev_q].
  - rdata = rsp_decerr_q ? 0 : device_rdata_i[rsp_dev_q].
  - err = rsp_decerr_q | device_err_i[rsp_dev_q].
- Devices must respond exactly one cycle after device_req_o. A device_rvalid_i with no matching pending request is ignored and never forwarded.
- Writes also produce a response (rvalid), with the same timing as reads.

## Timing
- Grant latency is 0 cycles: host_gnt_o is combinational from host_req_i and prio_q in the request cycle.
- Response latency is exactly 1 cycle after the grant, for both device and decode-error responses.
- Throughput is one transaction per cycle. Back-to-back grants are permitted, and the response for cycle N overlaps with the grant in cycle N+1.
- Fairness: a continuously requesting host is granted within NrHosts cycles.
- Same-cycle events: grant and response to the same host in one cycle is legal and both are visible. Every host requesting at once is resolved purely by prio_q.
- Reset:
  - While rst_i=1, all host_gnt_o, device_req_o and host_rvalid_o are 0, and host_rdata_o is 0.
  - State clears asynchronously on assertion.
  - A pending response is dropped by reset. The first grant is possible in the first cycle after rst_i deasserts.

## Test plan
- Single host 1 reads 0x100 while RAM returns 0xDEADBEEF -> gnt[1] in the request cycle, rvalid[1]=1 next cycle with rdata 0xDEADBEEF and err=0.
- Hosts 0, 1 and 2 request continuously from reset -> grants in order 0, 1, 2, 0, 1, 2. Each rvalid follows its grant by one cycle on the matching host only.
- Host 2 accesses 0x30000 (unmapped) -> gnt[2], no device_req_o, next cycle rvalid[2]=1 with err=1 and rdata=0.
- Host 0 requests alone for 3 cycles, then host 1 joins -> grants 0, 0, 0, 1, 0. prio_q wraps correctly.
- Host 1 writes 0x20004 (test utility) -> device_req_o[1]=1 with be and wdata forwarded, and rvalid[1] arrives one cycle later.
- rst_i asserted in the cycle after a grant -> rvalid suppressed and all outputs 0. After release, host 0 has priority on the first simultaneous request.

Source files
------------

// File: rtl/bus_rr_arbiter.sv
// Round-robin host arbiter and address router for the simulation system bus.
// Grants at most one host per cycle, routes the request to the first device
// whose (addr & mask) == base, and steers the single-cycle response back to
// the host that was granted. Unmapped accesses complete with a bus error.
module bus_rr_arbiter #(
    parameter int unsigned NrHosts      = 3,
    parameter int unsigned NrDevices    = 2,
    parameter int unsigned DataWidth    = 32,
    parameter int unsigned AddressWidth = 32
) (
    input  logic                                     clk_i,
    input  logic                                     rst_i,

    input  logic [NrHosts-1:0]                       host_req_i,
    output logic [NrHosts-1:0]                       host_gnt_o,
    input  logic [NrHosts-1:0][AddressWidth-1:0]     host_addr_i,
    input  logic [NrHosts-1:0]                       host_we_i,
    input  logic [NrHosts-1:0][DataWidth/8-1:0]      host_be_i,
    input  logic [NrHosts-1:0][DataWidth-1:0]        host_wdata_i,
    output logic [NrHosts-1:0]                       host_rvalid_o,
    output logic [NrHosts-1:0][DataWidth-1:0]        host_rdata_o,
    output logic [NrHosts-1:0]                       host_err_o,

    output logic [NrDevices-1:0]                     device_req_o,
    output logic [NrDevices-1:0][AddressWidth-1:0]   device_addr_o,
    output logic [NrDevices-1:0]                     device_we_o,
    output logic [NrDevices-1:0][DataWidth/8-1:0]    device_be_o,
    output logic [NrDevices-1:0][DataWidth-1:0]      device_wdata_o,
    input  logic [NrDevices-1:0]                     device_rvalid_i,
    input  logic [NrDevices-1:0][DataWidth-1:0]      device_rdata_i,
    input  logic [NrDevices-1:0]                     device_err_i,

    input  logic [NrDevices-1:0][AddressWidth-1:0]   cfg_device_addr_base,
    input  logic [NrDevices-1:0][AddressWidth-1:0]   cfg_device_addr_mask
);

    localparam int unsigned HostIdxW = (NrHosts   > 1) ? $clog2(NrHosts)   : 1;
    localparam int unsigned DevIdxW  = (NrDevices > 1) ? $clog2(NrDevices) : 1;

    // Arbitration state
    logic [HostIdxW-1:0]  prio_q;
    logic [NrHosts-1:0]   req;
    logic [HostIdxW-1:0]  win;
    logic                 gnt_any;

    // Decode results for the winning host
    logic [DevIdxW-1:0]   sel;
    logic                 hit;

    // In-flight response tracking
    logic                 rsp_pend_q;
    logic [HostIdxW-1:0]  rsp_host_q;
    logic [DevIdxW-1:0]   rsp_dev_q;
    logic                 rsp_decerr_q;

    // Response path after device selection
    logic                 rsp_valid;
    logic                 rsp_err;
    logic [DataWidth-1:0] rsp_data;

    // Requests are masked while reset is held so nothing is granted or routed.
    always_comb begin
        req = rst_i ? '0 : host_req_i;
    end

    // Round-robin scan starting at prio_q; the first requesting host wins.
    always_comb begin
        win     = '0;
        gnt_any = 1'b0;
        for (int unsigned off = 0; off < NrHosts; off++) begin
            if (!gnt_any && req[(32'(prio_q) + off) % NrHosts]) begin
                gnt_any = 1'b1;
                win     = HostIdxW'((32'(prio_q) + off) % NrHosts);
            end
        end
    end

    // One-hot grant to the winner.
    always_comb begin
        host_gnt_o      = '0;
        host_gnt_o[win] = gnt_any;
    end

    // Address decode of the winner's request; lowest matching device index wins.
    always_comb begin
        sel = '0;
        hit = 1'b0;
        for (int unsigned d = 0; d < NrDevices; d++) begin
            if (!hit &&
                ((host_addr_i[win] & cfg_device_addr_mask[d]) == cfg_device_addr_base[d])) begin
                hit = 1'b1;
                sel = DevIdxW'(d);
            end
        end
    end

    // Raise the selected device request and broadcast the winner's fields.
    always_comb begin
        device_req_o      = '0;
        device_req_o[sel] = gnt_any & hit;
        for (int unsigned d = 0; d < NrDevices; d++) begin
            device_addr_o[d]  = host_addr_i[win];
            device_we_o[d]    = host_we_i[win];
            device_be_o[d]    = host_be_i[win];
            device_wdata_o[d] = host_wdata_i[win];
        end
    end

    // Priority pointer advances past the winner only when a grant is made.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            prio_q <= '0;
        end else if (gnt_any) begin
            prio_q <= HostIdxW'((32'(win) + 1) % NrHosts);
        end
    end

    // Record who was granted and where the request went, for next-cycle return.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rsp_pend_q   <= 1'b0;
            rsp_host_q   <= '0;
            rsp_dev_q    <= '0;
            rsp_decerr_q <= 1'b0;
        end else begin
            rsp_pend_q <= gnt_any;
            if (gnt_any) begin
                rsp_host_q   <= win;
                rsp_dev_q    <= sel;
                rsp_decerr_q <= ~hit;
            end
        end
    end

    // Select the response source; device activity without a pending request is ignored.
    always_comb begin
        rsp_valid = rsp_pend_q & (rsp_decerr_q | device_rvalid_i[rsp_dev_q]);
        rsp_err   = rsp_decerr_q | device_err_i[rsp_dev_q];
        rsp_data  = rsp_decerr_q ? '0 : device_rdata_i[rsp_dev_q];
        if (rst_i) begin
            rsp_valid = 1'b0;
            rsp_data  = '0;
        end
    end

    // Steer valid/error to the recorded host; read data is broadcast to all hosts.
    always_comb begin
        host_rvalid_o             = '0;
        host_err_o                = '0;
        host_rvalid_o[rsp_host_q] = rsp_valid;
        host_err_o[rsp_host_q]    = rsp_valid & rsp_err;
        for (int unsigned h = 0; h < NrHosts; h++) begin
            host_rdata_o[h] = rsp_data;
        end
    end

    // Grants and device requests are never more than one-hot.
    a_gnt_onehot0 : assert property (@(posedge clk_i) disable iff (rst_i) $onehot0(host_gnt_o));
    a_dev_onehot0 : assert property (@(posedge clk_i) disable iff (rst_i) $onehot0(device_req_o));

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Scoreboard bench for bus_rr_arbiter: a stimulus process predicts grants and
// responses with a plain reference model, a device model answers forwarded
// requests, and a monitor compares DUT outputs on the falling clock edge.
module tb_bus_rr_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic [2:0]        host_req   = '0;
    logic [2:0]        host_gnt;
    logic [2:0][31:0]  host_addr  = '0;
    logic [2:0]        host_we    = '0;
    logic [2:0][3:0]   host_be    = '0;
    logic [2:0][31:0]  host_wdata = '0;
    logic [2:0]        host_rvalid;
    logic [2:0][31:0]  host_rdata;
    logic [2:0]        host_err;

    logic [1:0]        dev_req;
    logic [1:0][31:0]  dev_addr;
    logic [1:0]        dev_we;
    logic [1:0][3:0]   dev_be;
    logic [1:0][31:0]  dev_wdata;
    logic [1:0]        dev_rvalid = '0;
    logic [1:0][31:0]  dev_rdata  = '0;
    logic [1:0]        dev_err    = '0;

    logic [1:0][31:0]  cfg_base;
    logic [1:0][31:0]  cfg_mask;

    bus_rr_arbiter #(
        .NrHosts      (3),
        .NrDevices    (2),
        .DataWidth    (32),
        .AddressWidth (32)
    ) dut (
        .clk_i                (clk),
        .rst_i                (rst),
        .host_req_i           (host_req),
        .host_gnt_o           (host_gnt),
        .host_addr_i          (host_addr),
        .host_we_i            (host_we),
        .host_be_i            (host_be),
        .host_wdata_i         (host_wdata),
        .host_rvalid_o        (host_rvalid),
        .host_rdata_o         (host_rdata),
        .host_err_o           (host_err),
        .device_req_o         (dev_req),
        .device_addr_o        (dev_addr),
        .device_we_o          (dev_we),
        .device_be_o          (dev_be),
        .device_wdata_o       (dev_wdata),
        .device_rvalid_i      (dev_rvalid),
        .device_rdata_i       (dev_rdata),
        .device_err_i         (dev_err),
        .cfg_device_addr_base (cfg_base),
        .cfg_device_addr_mask (cfg_mask)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int passed = 0;

    task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (ok) passed++;
        else $display("FAIL %s @cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    endtask

    // Device behaviour shared by the device model and the reference model:
    // read data is a per-device key mixed with the address, writes fold in wdata/be.
    function automatic logic [31:0] dev_data(input int d, input logic [31:0] a, input logic we,
                                             input logic [3:0] be, input logic [31:0] wd);
        logic [31:0] key;
        key = (d == 0) ? 32'hDEADBFEF : 32'h5A5A0F0F;
        return key ^ a ^ (we ? (wd ^ {28'h0, be}) : 32'h0);
    endfunction

    function automatic logic dev_error(input int d, input logic [31:0] a);
        return (d == 1) && a[3];
    endfunction

    // Device model: answer one cycle after a request, otherwise emit random noise.
    logic [1:0]       cap_req = '0;
    logic [1:0][31:0] cap_addr, cap_wdata;
    logic [1:0]       cap_we;
    logic [1:0][3:0]  cap_be;

    initial forever begin
        @(negedge clk);
        cap_req   = dev_req;
        cap_addr  = dev_addr;
        cap_we    = dev_we;
        cap_be    = dev_be;
        cap_wdata = dev_wdata;
    end

    initial forever begin
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            if (cap_req[d]) begin
                dev_rvalid[d] = 1'b1;
                dev_rdata[d]  = dev_data(d, cap_addr[d], cap_we[d], cap_be[d], cap_wdata[d]);
                dev_err[d]    = dev_error(d, cap_addr[d]);
            end else begin
                dev_rvalid[d] = ($urandom_range(0, 3) == 0);
                dev_rdata[d]  = $urandom;
                dev_err[d]    = 1'($urandom_range(0, 1));
            end
        end
    end

    // Reference model and scoreboard.
    typedef struct {
        int          host;
        logic [31:0] data;
        logic        err;
        int          due;
    } rsp_t;

    rsp_t q[$];

    int          prio = 0;
    logic [2:0]  exp_gnt  = '0;
    logic [1:0]  exp_dreq = '0;
    int          exp_dsel = 0;
    logic [31:0] exp_addr;
    logic [36:0] exp_fields;

    task automatic step(input logic [2:0] req, input logic [2:0][31:0] a, input logic [2:0] we,
                        input logic [2:0][3:0] be, input logic [2:0][31:0] wd);
        int   win;
        int   dsel;
        rsp_t e;
        @(posedge clk);
        #1;
        rst        = 1'b0;
        host_req   = req;
        host_addr  = a;
        host_we    = we;
        host_be    = be;
        host_wdata = wd;

        win = -1;
        for (int k = 0; k < 3; k++) begin
            if (win < 0 && req[(prio + k) % 3]) win = (prio + k) % 3;
        end
        exp_gnt  = '0;
        exp_dreq = '0;
        if (win >= 0) begin
            prio = (win + 1) % 3;
            exp_gnt[win] = 1'b1;
            dsel = -1;
            for (int d = 0; d < 2; d++) begin
                if (dsel < 0 && ((a[win] & cfg_mask[d]) == cfg_base[d])) dsel = d;
            end
            e.host = win;
            e.due  = cyc + 1;
            if (dsel < 0) begin
                e.data = 32'h0;
                e.err  = 1'b1;
            end else begin
                exp_dreq[dsel] = 1'b1;
                exp_dsel   = dsel;
                exp_addr   = a[win];
                exp_fields = {we[win], be[win], wd[win]};
                e.data = dev_data(dsel, a[win], we[win], be[win], wd[win]);
                e.err  = dev_error(dsel, a[win]);
            end
            q.push_back(e);
        end
    endtask

    task automatic do_reset(input int n);
        @(posedge clk);
        #1;
        rst      = 1'b1;
        host_req = '0;
        q.delete();
        prio     = 0;
        exp_gnt  = '0;
        exp_dreq = '0;
        repeat (n - 1) @(posedge clk);
    endtask

    task automatic random_step();
        logic [2:0]       r;
        logic [2:0][31:0] a;
        logic [2:0]       w;
        logic [2:0][3:0]  b;
        logic [2:0][31:0] wd;
        r = 3'($urandom_range(0, 7));
        for (int h = 0; h < 3; h++) begin
            case ($urandom_range(0, 3))
                0: a[h] = 32'h0000_0000 | ($urandom & 32'hFFFC);
                1: a[h] = 32'h0002_0000 | ($urandom & 32'hFFFC);
                2: a[h] = 32'h0003_0000 | ($urandom & 32'hFFFC);
                default: a[h] = 32'h0001_0000 | ($urandom & 32'hFFFC);
            endcase
            w[h]  = 1'($urandom_range(0, 1));
            b[h]  = 4'($urandom);
            wd[h] = $urandom;
        end
        step(r, a, w, b, wd);
    endtask

    // Monitor: compare everything the DUT presents against the predictions.
    initial forever begin
        logic [2:0] exp_rv;
        bit         ok;
        rsp_t       e;
        @(negedge clk);
        if (rst) begin
            check(host_gnt == 3'b0 && dev_req == 2'b0 && host_rvalid == 3'b0 && host_rdata == '0,
                  "reset_outputs", {host_gnt, dev_req, host_rvalid}, 64'h0);
        end else begin
            check(host_gnt == exp_gnt, "grant", host_gnt, exp_gnt);
            check(dev_req == exp_dreq, "device_req", dev_req, exp_dreq);
            if (exp_dreq != 2'b0) begin
                check(dev_addr[exp_dsel] == exp_addr, "fwd_addr", dev_addr[exp_dsel], exp_addr);
                check({dev_we[exp_dsel], dev_be[exp_dsel], dev_wdata[exp_dsel]} == exp_fields,
                      "fwd_we_be_wdata", {dev_we[exp_dsel], dev_be[exp_dsel], dev_wdata[exp_dsel]},
                      exp_fields);
            end
            exp_rv = '0;
            if (q.size() > 0 && q[0].due == cyc) begin
                e = q.pop_front();
                exp_rv[e.host] = 1'b1;
                check(host_rvalid == exp_rv, "rvalid", host_rvalid, exp_rv);
                ok = 1'b1;
                for (int h = 0; h < 3; h++) if (host_rdata[h] !== e.data) ok = 1'b0;
                check(ok, "rdata", host_rdata[e.host], e.data);
                check(host_err[e.host] == e.err, "err", host_err[e.host], e.err);
            end else begin
                check(host_rvalid == exp_rv, "no_rvalid", host_rvalid, exp_rv);
            end
        end
    end

    // Directed scenarios followed by randomized traffic.
    initial begin
        logic [2:0][31:0] a;
        logic [2:0]       w;
        logic [2:0][3:0]  b;
        logic [2:0][31:0] wd;

        cfg_base[0] = 32'h0000_0000; cfg_mask[0] = 32'hFFFF_0000;
        cfg_base[1] = 32'h0002_0000; cfg_mask[1] = 32'hFFFF_0000;
        a = '0; w = '0; b = '0; wd = '0;
        repeat (3) @(posedge clk);

        // All hosts requesting from reset: 0,1,2,0,1,2
        a[0] = 32'h100; a[1] = 32'h20008; a[2] = 32'h204;
        repeat (6) step(3'b111, a, w, b, wd);
        step(3'b000, a, w, b, wd);

        // Host 1 reads 0x100 from RAM
        a = '0; a[1] = 32'h100;
        step(3'b010, a, w, b, wd);
        step(3'b000, a, w, b, wd);

        // Host 0 alone three cycles, then host 1 joins
        a[0] = 32'h40; a[1] = 32'h20010;
        repeat (3) step(3'b001, a, w, b, wd);
        repeat (2) step(3'b011, a, w, b, wd);
        step(3'b000, a, w, b, wd);

        // Host 2 unmapped access
        a[2] = 32'h30000;
        step(3'b100, a, w, b, wd);
        step(3'b000, a, w, b, wd);

        // Host 1 write to the test utility
        a[1] = 32'h20004; w[1] = 1'b1; b[1] = 4'b0110; wd[1] = 32'hCAFEF00D;
        step(3'b010, a, w, b, wd);
        step(3'b000, a, w, b, wd);

        // Reset in the cycle after a grant; host 0 wins first afterwards
        w = '0;
        step(3'b010, a, w, b, wd);
        do_reset(2);
        step(3'b111, a, w, b, wd);
        step(3'b111, a, w, b, wd);
        step(3'b000, a, w, b, wd);

        repeat (300) random_step();

        // Overlapping regions: device 1 catches everything, device 0 must still win its range
        cfg_base[1] = 32'h0; cfg_mask[1] = 32'h0;
        repeat (200) random_step();

        step(3'b000, a, w, b, wd);
        step(3'b000, a, w, b, wd);
        @(negedge clk);
        #1;
        check(q.size() == 0, "drain", q.size(), 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
